// File: rtl/rf_wb_queue_if.sv
// Producer-side handshake and register-file write port of the writeback queue.
// The queue takes the slave view; the producer / register file side takes the master view.
interface rf_wb_queue_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_waddr;
    logic [DW-1:0] in_wdata;
    logic          rf_hold;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    modport master (
        output in_valid, in_waddr, in_wdata, rf_hold,
        input  in_ready, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  in_valid, in_waddr, in_wdata, rf_hold,
        output in_ready, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/rf_wb_queue.sv
// Writeback FIFO in front of the 2R1W register file, with youngest-wins forwarding lookups.
// Latency: an accepted result can be written at the next edge at the earliest; no in->rf bypass.
// Backpressure: in_ready = count < DEPTH (pre-edge state only); rf_hold stalls draining.
module rf_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          resetn,
    rf_wb_queue_if.slave  wb,
    input  logic [AW-1:0] fwd_raddr1,
    output logic          fwd_hit1,
    output logic [DW-1:0] fwd_data1,
    input  logic [AW-1:0] fwd_raddr2,
    output logic          fwd_hit2,
    output logic [DW-1:0] fwd_data2,
    output logic [CW-1:0] count,
    output logic          empty
);
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          push;
    logic          pop;
    logic [PW-1:0] idx;

    assign wb.in_ready = (cnt < CW'(DEPTH));
    assign accept      = wb.in_valid & wb.in_ready;
    // Writes to r0 complete the handshake but never occupy an entry.
    assign push        = accept & (wb.in_waddr != '0);
    assign pop         = (cnt != '0) & ~wb.rf_hold;

    assign wb.rf_we    = pop;
    assign wb.rf_waddr = pop ? mem[head].addr : '0;
    assign wb.rf_wdata = pop ? mem[head].data : '0;
    assign count       = cnt;
    assign empty       = (cnt == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[tail] <= '{addr: wb.in_waddr, data: wb.in_wdata};
    end

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_data1 = '0;
        fwd_hit2  = 1'b0;
        fwd_data2 = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < cnt) begin
                if ((fwd_raddr1 != '0) && (mem[idx].addr == fwd_raddr1)) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = mem[idx].data;
                end
                if ((fwd_raddr2 != '0) && (mem[idx].addr == fwd_raddr2)) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = mem[idx].data;
                end
            end
        end
    end
endmodule

// File: tb/tb_rf_wb_queue.sv
// Bench for rf_wb_queue: directed vector table, hand sequences, and random traffic
// against a queue-based reference model.
module tb_rf_wb_queue;
    logic        clk = 1'b0;
    logic        resetn;
    logic [4:0]  fwd_raddr1, fwd_raddr2;
    logic        fwd_hit1, fwd_hit2;
    logic [31:0] fwd_data1, fwd_data2;
    logic [2:0]  count;
    logic        empty;

    int n_checks = 0;
    int n_fail   = 0;

    rf_wb_queue_if #(.AW(5), .DW(32)) wb ();

    rf_wb_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .wb         (wb),
        .fwd_raddr1 (fwd_raddr1),
        .fwd_hit1   (fwd_hit1),
        .fwd_data1  (fwd_data1),
        .fwd_raddr2 (fwd_raddr2),
        .fwd_hit2   (fwd_hit2),
        .fwd_data2  (fwd_data2),
        .count      (count),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        hold;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        e_rdy;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_h1;
        logic [31:0] e_d1;
        logic        e_h2;
        logic [31:0] e_d2;
        logic [2:0]  e_cnt;
    } vec_t;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    vec_t vecs [27];
    ent_t mq [$];

    function automatic vec_t mk(input logic vld, input logic [4:0] wa, input logic [31:0] wd,
                                input logic hold, input logic [4:0] r1, input logic [4:0] r2,
                                input logic e_rdy, input logic e_we, input logic [4:0] e_wa,
                                input logic [31:0] e_wd, input logic e_h1, input logic [31:0] e_d1,
                                input logic e_h2, input logic [31:0] e_d2, input logic [2:0] e_cnt);
        vec_t v;
        v.vld = vld; v.wa = wa; v.wd = wd; v.hold = hold; v.r1 = r1; v.r2 = r2;
        v.e_rdy = e_rdy; v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd;
        v.e_h1 = e_h1; v.e_d1 = e_d1; v.e_h2 = e_h2; v.e_d2 = e_d2; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [4:0] wa, input logic [31:0] wd,
                         input logic hold, input logic [4:0] r1, input logic [4:0] r2);
        wb.in_valid = vld;
        wb.in_waddr = wa;
        wb.in_wdata = wd;
        wb.rf_hold  = hold;
        fwd_raddr1  = r1;
        fwd_raddr2  = r2;
    endtask

    task automatic check_all(input string tag, input logic e_rdy, input logic e_we,
                             input logic [4:0] e_wa, input logic [31:0] e_wd,
                             input logic e_h1, input logic [31:0] e_d1,
                             input logic e_h2, input logic [31:0] e_d2, input logic [2:0] e_cnt);
        cmp({tag, ".in_ready"}, 64'(wb.in_ready), 64'(e_rdy));
        cmp({tag, ".rf_we"},    64'(wb.rf_we),    64'(e_we));
        cmp({tag, ".rf_waddr"}, 64'(wb.rf_waddr), 64'(e_wa));
        cmp({tag, ".rf_wdata"}, 64'(wb.rf_wdata), 64'(e_wd));
        cmp({tag, ".fwd_hit1"}, 64'(fwd_hit1),    64'(e_h1));
        cmp({tag, ".fwd_data1"},64'(fwd_data1),   64'(e_d1));
        cmp({tag, ".fwd_hit2"}, 64'(fwd_hit2),    64'(e_h2));
        cmp({tag, ".fwd_data2"},64'(fwd_data2),   64'(e_d2));
        cmp({tag, ".count"},    64'(count),       64'(e_cnt));
        cmp({tag, ".empty"},    64'(empty),       64'(e_cnt == 3'd0));
    endtask

    // Reference lookup: scan pending results from youngest to oldest.
    function automatic void model_fwd(input logic [4:0] ra, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        if (ra != 5'd0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].a == ra) begin
                    h = 1'b1;
                    d = mq[i].d;
                    break;
                end
            end
        end
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        stalled, vld, hold, m_rdy, m_we, h1, h2;
        logic [4:0]  wa, r1, r2, m_wa;
        logic [31:0] wd, m_wd, d1, d2;

        //      vld wa     wd            hold r1 r2  rdy we ewa ewd          h1 d1           h2 d2      cnt
        vecs[0]  = mk(0, 0, 32'h0,        0, 0, 0,  1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,  0);
        vecs[1]  = mk(1, 5, 32'h12345678, 0, 5, 0,  1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,  0);
        vecs[2]  = mk(0, 0, 32'h0,        0, 5, 0,  1, 1, 5, 32'h12345678, 1, 32'h12345678, 0, 32'h0,  1);
        vecs[3]  = mk(0, 0, 32'h0,        0, 5, 0,  1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,  0);
        vecs[4]  = mk(1, 1, 32'h11,       1, 0, 0,  1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,  0);
        vecs[5]  = mk(1, 2, 32'h22,       1, 1, 0,  1, 0, 0, 32'h0,        1, 32'h11,       0, 32'h0,  1);
        vecs[6]  = mk(1, 3, 32'h33,       1, 0, 0,  1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,  2);
        vecs[7]  = mk(1, 4, 32'h44,       1, 0, 0,  1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,  3);
        vecs[8]  = mk(1, 5, 32'h55,       1, 0, 0,  0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,  4);
        vecs[9]  = mk(1, 5, 32'h55,       1, 4, 5,  0, 0, 0, 32'h0,        1, 32'h44,       0, 32'h0,  4);
        vecs[10] = mk(1, 5, 32'h55,       0, 0, 0,  0, 1, 1, 32'h11,       0, 32'h0,        0, 32'h0,  4);
        vecs[11] = mk(1, 5, 32'h55,       0, 0, 0,  1, 1, 2, 32'h22,       0, 32'h0,        0, 32'h0,  3);
        vecs[12] = mk(0, 0, 32'h0,        0, 0, 5,  1, 1, 3, 32'h33,       0, 32'h0,        1, 32'h55, 3);
        vecs[13] = mk(0, 0, 32'h0,        0, 0, 0,  1, 1, 4, 32'h44,       0, 32'h0,        0, 32'h0,  2);
        vecs[14] = mk(0, 0, 32'h0,        0, 0, 0,  1, 1, 5, 32'h55,       0, 32'h0,        0, 32'h0,  1);
        vecs[15] = mk(0, 0, 32'h0,        0, 0, 0,  1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,  0);
        vecs[16] = mk(1, 7, 32'hA,        1, 0, 0,  1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,  0);
        vecs[17] = mk(1, 3, 32'hB,        1, 7, 0,  1, 0, 0, 32'h0,        1, 32'hA,        0, 32'h0,  1);
        vecs[18] = mk(1, 7, 32'hC,        1, 0, 0,  1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,  2);
        vecs[19] = mk(0, 0, 32'h0,        1, 7, 3,  1, 0, 0, 32'h0,        1, 32'hC,        1, 32'hB,  3);
        vecs[20] = mk(0, 0, 32'h0,        1, 0, 9,  1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,  3);
        vecs[21] = mk(0, 0, 32'h0,        0, 7, 3,  1, 1, 7, 32'hA,        1, 32'hC,        1, 32'hB,  3);
        vecs[22] = mk(0, 0, 32'h0,        0, 7, 3,  1, 1, 3, 32'hB,        1, 32'hC,        1, 32'hB,  2);
        vecs[23] = mk(0, 0, 32'h0,        0, 7, 3,  1, 1, 7, 32'hC,        1, 32'hC,        0, 32'h0,  1);
        vecs[24] = mk(0, 0, 32'h0,        0, 7, 3,  1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,  0);
        vecs[25] = mk(1, 0, 32'hDEAD,     0, 0, 0,  1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,  0);
        vecs[26] = mk(0, 0, 32'h0,        0, 0, 0,  1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,  0);

        resetn = 1'b0;
        drive(1'b1, 5'd3, 32'hFFFF, 1'b0, 5'd3, 5'd3);
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 27; i++) begin
            drive(vecs[i].vld, vecs[i].wa, vecs[i].wd, vecs[i].hold, vecs[i].r1, vecs[i].r2);
            #1;
            check_all($sformatf("vec[%0d]", i), vecs[i].e_rdy, vecs[i].e_we, vecs[i].e_wa,
                      vecs[i].e_wd, vecs[i].e_h1, vecs[i].e_d1, vecs[i].e_h2, vecs[i].e_d2,
                      vecs[i].e_cnt);
            @(posedge clk);
            #1;
        end

        // Back-to-back pushes with no hold: each result is written the cycle after it is accepted.
        for (int i = 0; i < 14; i++) begin
            drive(i < 12, 5'(i + 1), 32'h100 + 32'(i), 1'b0, 5'd0, 5'd0);
            #1;
            if (i == 0 || i == 13)
                check_all($sformatf("stream[%0d]", i), 1, 0, 0, 0, 0, 0, 0, 0, 0);
            else
                check_all($sformatf("stream[%0d]", i), 1, 1, 5'(i), 32'h100 + 32'(i - 1),
                          0, 0, 0, 0, 1);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset with three queued entries.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(20 + i), 32'hBEEF0 + 32'(i), 1'b1, 5'd0, 5'd0);
            @(posedge clk);
            #1;
        end
        drive(0, 0, 0, 0, 5'd21, 5'd0);
        #1;
        cmp("midrst.pre_we", 64'(wb.rf_we), 64'd1);
        cmp("midrst.pre_count", 64'(count), 64'd3);
        #1;
        resetn = 1'b0;
        #1;
        check_all("midrst.asserted", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_all($sformatf("midrst.after[%0d]", i), 1, 0, 0, 0, 0, 0, 0, 0, 0);
            @(posedge clk);
            #1;
        end

        // Random traffic against the reference queue model.
        mq.delete();
        stalled = 1'b0;
        vld = 1'b0; wa = '0; wd = '0;
        for (int c = 0; c < 600; c++) begin
            if (!stalled) begin
                vld = ($urandom_range(0, 3) != 0);
                wa  = 5'($urandom_range(0, 7));
                wd  = $urandom;
            end
            hold = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
            r1   = 5'($urandom_range(0, 7));
            r2   = 5'($urandom_range(0, 7));
            drive(vld, wa, wd, hold, r1, r2);
            #1;
            m_rdy = (mq.size() < 4);
            m_we  = (mq.size() > 0) && !hold;
            m_wa  = m_we ? mq[0].a : 5'd0;
            m_wd  = m_we ? mq[0].d : 32'd0;
            model_fwd(r1, h1, d1);
            model_fwd(r2, h2, d2);
            check_all($sformatf("rand[%0d]", c), m_rdy, m_we, m_wa, m_wd, h1, d1, h2, d2,
                      3'(mq.size()));
            stalled = vld && !m_rdy;
            @(posedge clk);
            #1;
            if (m_we) void'(mq.pop_front());
            if (vld && m_rdy && wa != 5'd0) mq.push_back('{a: wa, d: wd});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
